// File: rtl/msx_mouse_host.sv
// MSX mouse host: strobes the DB9 port, reads four nibbles per poll and emits a PS/2-style packet.
// Define MSX_MOUSE_IDLE_EN to emit a packet on every poll, even with no motion or button change.
module msx_mouse_host #(
  parameter int SETTLE_CYC = 430,
  parameter int POLL_CYC   = 358000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  joy_in,
  output logic        strobe,
  output logic [24:0] mouse_out,
  output logic        busy
);

  localparam int PW = $clog2(POLL_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, XH, XL, YH, YL, EMIT} state_t;

  state_t        r_state, w_next;
  logic [5:0]    r_sync1, r_sync2;
  logic [5:0]    w_joy;
  logic [PW-1:0] r_poll;
  logic [SW-1:0] r_settle;
  logic [3:0]    r_xh, r_xl, r_yh;
  logic [1:0]    r_last_btn;
  logic [24:0]   r_mouse;
  logic          w_sample, w_poll_wrap, w_changed, w_fire;
  logic [7:0]    w_raw_x, w_raw_y, w_dx;

  assign w_joy       = ~r_sync2;
  assign w_sample    = (r_settle == SETTLE_LAST);
  assign w_poll_wrap = (r_poll == POLL_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    strobe = 1'b0;
    busy   = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_poll_wrap) w_next = XH;
      end
      XH: begin
        strobe = 1'b1;
        if (w_sample) w_next = XL;
      end
      XL: if (w_sample) w_next = YH;
      YH: begin
        strobe = 1'b1;
        if (w_sample) w_next = YL;
      end
      YL:      if (w_sample) w_next = EMIT;
      EMIT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (!enable) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= joy_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-runs across the read sequence so poll starts stay POLL_CYC apart.
  always_ff @(posedge clk) begin
    if (reset || !enable || w_poll_wrap) r_poll <= '0;
    else                                 r_poll <= r_poll + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || (w_next != r_state) || (r_state == IDLE)) r_settle <= '0;
    else if (!w_sample)                                    r_settle <= r_settle + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_xh <= '0;
      r_xl <= '0;
      r_yh <= '0;
    end else if (w_sample) begin
      case (r_state)
        XH:      r_xh <= w_joy[3:0];
        XL:      r_xl <= w_joy[3:0];
        YH:      r_yh <= w_joy[3:0];
        default: ;
      endcase
    end
  end

  // The YL nibble and buttons are used live so the packet is visible during EMIT.
  assign w_raw_x = {r_xh, r_xl};
  assign w_raw_y = {r_yh, w_joy[3:0]};
  assign w_dx    = (w_raw_x == 8'h80) ? 8'h7F : (~w_raw_x + 8'd1);

`ifdef MSX_MOUSE_IDLE_EN
  assign w_changed = 1'b1;
`else
  assign w_changed = (w_dx != 8'h00) || (w_raw_y != 8'h00) || (w_joy[5:4] != r_last_btn);
`endif

  assign w_fire = enable && (r_state == YL) && w_sample && w_changed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mouse    <= '0;
      r_last_btn <= '0;
    end else if (w_fire) begin
      r_mouse    <= {~r_mouse[24], w_raw_y, w_dx, 5'b0, 1'b0, w_joy[5:4]};
      r_last_btn <= w_joy[5:4];
    end
  end

  assign mouse_out = r_mouse;

endmodule

// File: tb/tb_msx_mouse_host.sv
// Bench for msx_mouse_host: DB9 mouse model driven by strobe, packet table, random polls, abort cases.
module tb_msx_mouse_host;
  logic        clk = 1'b0;
  logic        reset, enable;
  logic [5:0]  joy_in;
  logic        strobe, busy;
  logic [24:0] mouse_out;

  always #5 clk = ~clk;

  msx_mouse_host #(.SETTLE_CYC(4), .POLL_CYC(40)) dut (
    .clk(clk), .reset(reset), .enable(enable), .joy_in(joy_in),
    .strobe(strobe), .mouse_out(mouse_out), .busy(busy)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0]  m_rx = 8'h00, m_ry = 8'h00;
  logic [1:0]  m_b = 2'b00;
  int          mph = 0;
  logic        ps = 1'b0;
  logic [24:0] exp_mo = '0;
  logic [1:0]  last_b = 2'b00;
  int          t0 = 0, prev_t0 = 0, busy_len = 0, mo_chg = -1;
  int          e_t[$];

  typedef struct {
    logic [7:0] rx, ry;
    logic [1:0] b;
    logic       emit;
    logic [7:0] dx, dy;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; sample #1 after the edge and let the mouse present the nibble for the current phase.
  task automatic step();
    logic [3:0] nib;
    @(posedge clk); #1;
    cyc++;
    if (busy !== 1'b1) mph = 0;
    else if (strobe !== ps) mph++;
    ps = strobe;
    case (mph)
      1:       nib = m_rx[7:4];
      2:       nib = m_rx[3:0];
      3:       nib = m_ry[7:4];
      default: nib = m_ry[3:0];
    endcase
    joy_in = ~{m_b, nib};
  endtask

  task automatic model(input logic [7:0] rx, input logic [7:0] ry, input logic [1:0] b);
    int sx, dxi;
    logic [7:0] dx;
    logic emit;
    sx  = int'($signed(rx));
    dxi = -sx;
    if (dxi > 127) dxi = 127;
    dx   = 8'(dxi);
    emit = (dx != 0) || (ry != 0) || (b != last_b);
`ifdef MSX_MOUSE_IDLE_EN
    emit = 1'b1;
`endif
    if (emit) begin
      exp_mo = {~exp_mo[24], ry, dx, 6'b0, b};
      last_b = b;
    end
  endtask

  task automatic run_poll(input logic [7:0] rx, input logic [7:0] ry, input logic [1:0] b);
    int n;
    logic [24:0] pm;
    logic pst;
    m_rx = rx; m_ry = ry; m_b = b;
    pm = mouse_out;
    pst = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin step(); n++; end
    check("poll_start", {31'b0, busy}, 32'd1);
    prev_t0 = t0; t0 = cyc;
    e_t.delete(); busy_len = 0; mo_chg = -1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      busy_len++;
      if (strobe !== pst) e_t.push_back(cyc - t0);
      pst = strobe;
      if (mouse_out !== pm && mo_chg < 0) mo_chg = cyc - t0;
      pm = mouse_out;
      step(); n++;
    end
    check("poll_end", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_rel;
    logic e;
    tbl[0] = '{8'h04, 8'hFD, 2'b00, 1'b1, 8'hFC, 8'hFD};
    tbl[1] = '{8'h80, 8'h00, 2'b00, 1'b1, 8'h7F, 8'h00};
    tbl[2] = '{8'h00, 8'h00, 2'b01, 1'b1, 8'h00, 8'h00};
    tbl[3] = '{8'h00, 8'h00, 2'b01, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{8'h00, 8'h00, 2'b01, 1'b0, 8'h00, 8'h00};
    tbl[5] = '{8'hFF, 8'h7F, 2'b10, 1'b1, 8'h01, 8'h7F};
    tbl[6] = '{8'h7F, 8'h80, 2'b11, 1'b1, 8'h81, 8'h80};
    tbl[7] = '{8'h01, 8'h00, 2'b00, 1'b1, 8'hFF, 8'h00};

    // Reset wins over enable.
    reset = 1'b1; enable = 1'b1; joy_in = 6'h3F;
    repeat (3) step();
    check("reset_strobe", {31'b0, strobe}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_mouse_out", {7'b0, mouse_out}, 32'd0);
    reset = 1'b0;
    t_rel = cyc;

    for (int i = 0; i < 8; i++) begin
      run_poll(tbl[i].rx, tbl[i].ry, tbl[i].b);
      e = tbl[i].emit;
`ifdef MSX_MOUSE_IDLE_EN
      e = 1'b1;
`endif
      if (e) begin
        exp_mo = {~exp_mo[24], tbl[i].dy, tbl[i].dx, 6'b0, tbl[i].b};
        last_b = tbl[i].b;
      end
      check($sformatf("tbl%0d_mouse_out", i), {7'b0, mouse_out}, {7'b0, exp_mo});
      check($sformatf("tbl%0d_busy_len", i), busy_len, 32'd17);
      check($sformatf("tbl%0d_emit_latency", i), mo_chg, e ? 32'd16 : 32'hFFFF_FFFF);
      if (i == 0) begin
        check("first_poll_after_reset", t0 - t_rel, 32'd40);
        check("strobe_edge_count", e_t.size(), 32'd4);
        for (int k = 0; k < 4; k++)
          check($sformatf("strobe_edge%0d", k), (k < e_t.size()) ? e_t[k] : -1, 32'(4 * k));
      end else begin
        check($sformatf("tbl%0d_poll_period", i), t0 - prev_t0, 32'd40);
      end
    end

    for (int r = 0; r < 20; r++) begin
      logic [7:0] rx, ry;
      logic [1:0] b;
      rx = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      ry = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      b  = 2'($urandom_range(0, 3));
      model(rx, ry, b);
      run_poll(rx, ry, b);
      check($sformatf("rnd%0d_mouse_out", r), {7'b0, mouse_out}, {7'b0, exp_mo});
    end

    // Enable dropped during YH.
    m_rx = 8'h10; m_ry = 8'h20; m_b = 2'b00;
    n = 0;
    while (mph != 3 && n < 200) begin step(); n++; end
    check("reach_yh", mph, 32'd3);
    step();
    enable = 1'b0;
    step();
    check("drop_strobe", {31'b0, strobe}, 32'd0);
    check("drop_busy", {31'b0, busy}, 32'd0);
    check("drop_mouse_out", {7'b0, mouse_out}, {7'b0, exp_mo});
    repeat (5) step();
    check("drop_idle", {31'b0, busy}, 32'd0);
    enable = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin step(); n++; end
    check("reenable_delay", n, 32'd40);
    model(8'h10, 8'h20, 2'b00);
    run_poll(8'h10, 8'h20, 2'b00);
    check("after_drop_mouse_out", {7'b0, mouse_out}, {7'b0, exp_mo});

    // Reset pulsed during XL.
    m_rx = 8'h05; m_ry = 8'h06; m_b = 2'b01;
    n = 0;
    while (mph != 2 && n < 200) begin step(); n++; end
    check("reach_xl", mph, 32'd2);
    step();
    reset = 1'b1;
    step();
    check("rst_mid_strobe", {31'b0, strobe}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_mouse_out", {7'b0, mouse_out}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    exp_mo = '0; last_b = 2'b00;
    m_rx = 8'h00; m_ry = 8'h00; m_b = 2'b00;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin step(); n++; end
    check("rst_release_delay", n, 32'd40);
    model(8'h00, 8'h00, 2'b00);
    run_poll(8'h00, 8'h00, 2'b00);
    check("after_rst_mouse_out", {7'b0, mouse_out}, {7'b0, exp_mo});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/msx_mouse_host.md
MSX_MOUSE_HOST -- requirements
Module: msx_mouse_host

Interface
REQ-001 The block SHALL have a parameter SETTLE_CYC, default 430, giving clocks between a strobe edge and nibble sample (20 us at 21.48 MHz).
REQ-002 The block SHALL have a parameter POLL_CYC, default 358000, giving clocks from one read-sequence start to the next (60 Hz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: 1 runs the polling sequence; 0 holds the block idle.
REQ-006 The block SHALL have port joy_in, input, 6 bits, active-low DB9 pins: [3:0] data nibble (pins 4..1, [3]=MSB), [4] button 1, [5] button 2.
REQ-007 The block SHALL have port strobe, output, 1 bit: drives DB9 pin 8 toward the mouse.
REQ-008 The block SHALL have port mouse_out, output, 25 bits, PS/2-style packet: [24] toggle, [23:16] dy, [15:8] dx, [2:0] buttons {0, btn2, btn1}, [7:3] zero.
REQ-009 The block SHALL have port busy, output, 1 bit: 1 while a read sequence is in progress.

Function
REQ-010 joy_in SHALL pass through a 2-flop synchronizer and be inverted; all sampling SHALL use the synchronized, inverted value.
REQ-011 The FSM states SHALL be IDLE, XH, XL, YH, YL and EMIT.
REQ-012 In IDLE, the poll counter SHALL count to POLL_CYC-1, then move to XH and restart the counter.
REQ-013 Strobe SHALL be 1 in XH and YH, and 0 in IDLE, XL, YL and EMIT.
REQ-014 Each of XH, XL, YH and YL SHALL wait SETTLE_CYC clocks, sample the nibble on the last cycle, then advance in the order XH->XL->YH->YL->EMIT.
REQ-015 Sampled nibbles SHALL form raw_x = {XH,XL} and raw_y = {YH,YL} as two's-complement 8-bit values (MSX sense: +X left, +Y up).
REQ-016 dx SHALL equal -raw_x, saturating so that raw_x = 0x80 gives dx = 0x7F; dy SHALL equal raw_y unchanged.
REQ-017 Buttons SHALL be sampled on the YL sample cycle.
REQ-018 In EMIT, if dx != 0, dy != 0, or buttons differ from the last emitted buttons, mouse_out[23:0] SHALL update and mouse_out[24] SHALL invert in that same cycle; otherwise mouse_out SHALL hold.
REQ-019 EMIT SHALL last exactly 1 clock and then return to IDLE.
REQ-020 Latency from the YL sample cycle to the mouse_out update SHALL be 1 clock.
REQ-021 busy SHALL be 1 in XH through EMIT and 0 in IDLE.
REQ-022 If enable goes 0 in any state, the FSM SHALL go to IDLE on the next clock with strobe 0, discard partial nibbles, emit nothing, and clear the poll counter.
REQ-023 When enable returns to 1, the first sequence SHALL start POLL_CYC clocks later.
REQ-024 If enable and reset are both asserted, reset SHALL take priority.
REQ-025 The settle counter SHALL reload at every state entry and SHALL NOT wrap.
REQ-026 The poll counter SHALL wrap to 0 after POLL_CYC-1.

Reset
REQ-027 On reset, the state SHALL be IDLE, and strobe, busy, mouse_out, last buttons, the counters and the synchronizers SHALL all be 0.
REQ-028 Reset asserted mid-sequence SHALL abort it with no packet, strobe going 0 on the next clock.

Configuration
REQ-029 The macro MSX_MOUSE_IDLE_EN SHALL control packet emission.
REQ-030 With MSX_MOUSE_IDLE_EN defined, EMIT SHALL always update mouse_out and invert the toggle, even with zero motion and unchanged buttons.
REQ-031 Without MSX_MOUSE_IDLE_EN, emission SHALL follow REQ-018.

Verification
REQ-032 Scenario: mouse model returns nibbles F,B then 0,2 on joy_in (active-low; raw_x=0x04, raw_y=0xFD) -> mouse_out[15:8]=0xFC, [23:16]=0xFD, [24] inverted once.
REQ-033 Scenario: strobe edge timing with SETTLE_CYC=4, POLL_CYC=40 -> edges at poll+0, +4, +8, +12; strobe ends 0; busy high for 17 clocks.
REQ-034 Scenario: raw_x=0x80, raw_y=0x00 -> dx=0x7F, dy=0x00, packet emitted.
REQ-035 Scenario: zero motion with btn1 pressed, then two more zero-motion polls -> one packet with buttons=3'b001, then no toggle change (without macro); toggle inverts every poll (with macro).
REQ-036 Scenario: enable dropped during YH -> strobe 0 next clock, busy 0, mouse_out unchanged, next sequence starts POLL_CYC clocks after re-enable.
REQ-037 Scenario: reset pulsed during XL -> all outputs 0 next clock, no packet.
